iob_soc_versat_axi_ram: RTL and testbench

//  AXI4 subordinate RAM that answers one SoC AXI manager port (ext_mem0 or VERSAT0) in simulation/FPGA wrappers.

---
 rtl/iob_soc_versat_axi_ram_pkg.sv | 35 +++
 rtl/iob_soc_versat_axi_ram_mem.sv | 57 +++++
 rtl/iob_soc_versat_axi_ram.sv | 270 +++++++++++++++++++++++++++
 tb/tb_iob_soc_versat_axi_ram.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_soc_versat_axi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_soc_versat_axi_ram_pkg
// Description : Shared constants, FSM state types and a burst helper for the
//               AXI4 subordinate RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_soc_versat_axi_ram_pkg;

    // AXI burst and response encodings
    localparam logic [1:0] c_axi_burst_fixed = 2'b00;
    localparam logic [1:0] c_axi_resp_okay   = 2'b00;
    localparam logic [1:0] c_axi_resp_slverr = 2'b10;

    // Write channel FSM
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Read channel FSM
    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    // FIXED bursts keep the same word; INCR, WRAP and the reserved encoding
    // all advance one word per beat.
    function automatic logic burst_holds(input logic [1:0] burst);
        return burst == c_axi_burst_fixed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_soc_versat_axi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : iob_soc_versat_axi_ram_mem
// Description : Two-port RAM. Port A writes with per-byte enables, port B
//               reads into an output register that only updates on i_re,
//               so the read value is held while the reader stalls.
//               Same-word read/write in one cycle returns the old word.
// Ports       : clk, rst (async, active-high, output register only)
//               i_we, i_waddr, i_wstrb, i_wdata : write port
//               i_re, i_raddr, o_rdata          : read port
// Revision    : 1.0 - initial release
// ============================================================================
module iob_soc_versat_axi_ram_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int c_nbytes = DATA_W / 8;

    logic [DATA_W-1:0] r_ram [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (i_wstrb[b]) begin
                    r_ram[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking update of r_ram above means this samples the pre-write
    // word on a same-address collision (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_ram[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/iob_soc_versat_axi_ram.sv
`default_nettype none
// ============================================================================
// Module      : iob_soc_versat_axi_ram
// Description : AXI4 subordinate RAM with independent read and write FSMs
//               over a 2-port byte-enable RAM. INCR/FIXED bursts up to
//               2**AXI_LEN_W beats, one outstanding write and one read burst,
//               full backpressure on R and B.
// Ports       : clk_i, arst_i (async, active-high), cke_i (freezes state)
//               axi_aw*  / axi_w* / axi_b* : write address, data, response
//               axi_ar*  / axi_r*          : read address, data
//               lock/cache/prot/qos/size inputs are accepted and ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_soc_versat_axi_ram
    import iob_soc_versat_axi_ram_pkg::*;
#(
    parameter int    AXI_ID_W   = 4,
    parameter int    AXI_ADDR_W = 24,
    parameter int    AXI_DATA_W = 32,
    parameter int    AXI_LEN_W  = 8,
    parameter int    MEM_ADDR_W = 16,
    parameter string HEXFILE    = "none"
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    // write address
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [2:0]              axi_awprot_i,
    input  logic [3:0]              axi_awqos_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    // write data
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    // write response
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    // read address
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [2:0]              axi_arprot_i,
    input  logic [3:0]              axi_arqos_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    // read data
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    // Byte offset bits dropped from the AXI address to form the word index
    localparam int c_off = $clog2(AXI_DATA_W / 8);

    localparam logic [AXI_LEN_W-1:0]  c_len_one  = 1;
    localparam logic [AXI_LEN_W:0]    c_rcnt_one = 1;
    localparam logic [MEM_ADDR_W-1:0] c_word_one = 1;

    // RAM preload is done by the simulation wrapper writing u_mem.r_ram
    // hierarchically; the parameter only carries the file name through.
    if (HEXFILE != "none") begin : g_hexfile
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t               r_wstate;
    wr_state_t               w_wstate_nxt;
    logic [AXI_ID_W-1:0]     r_aw_id;
    logic [MEM_ADDR_W-1:0]   r_waddr;
    logic [AXI_LEN_W-1:0]    r_aw_len;
    logic [AXI_LEN_W-1:0]    r_wcnt;
    logic                    r_aw_fixed;
    logic                    r_werr;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_w_final;

    assign w_aw_hs   = cke_i & axi_awvalid_i & (r_wstate == W_IDLE);
    assign w_w_hs    = cke_i & axi_wvalid_i  & (r_wstate == W_DATA);
    assign w_b_hs    = cke_i & axi_bready_i  & (r_wstate == W_RESP);
    assign w_w_final = (r_wcnt == r_aw_len);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wstate <= W_IDLE;
        end else if (cke_i) begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                axi_awready_o = 1'b1;
                if (w_aw_hs) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                axi_wready_o = 1'b1;
                // The beat count alone ends the burst; wlast is only audited.
                if (w_w_hs && w_w_final) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                axi_bvalid_o = 1'b1;
                if (w_b_hs) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_aw_id    <= '0;
            r_waddr    <= '0;
            r_aw_len   <= '0;
            r_aw_fixed <= 1'b0;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_id    <= axi_awid_i;
            r_waddr    <= axi_awaddr_i[MEM_ADDR_W+c_off-1 -: MEM_ADDR_W];
            r_aw_len   <= axi_awlen_i;
            r_aw_fixed <= burst_holds(axi_awburst_i);
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
        end else if (w_w_hs) begin
            r_wcnt <= r_wcnt + c_len_one;
            if (!r_aw_fixed) r_waddr <= r_waddr + c_word_one;
            // wlast must appear exactly on the final beat
            if (w_w_final ? !axi_wlast_i : axi_wlast_i) r_werr <= 1'b1;
        end
    end

    assign axi_bid_o   = r_aw_id;
    assign axi_bresp_o = ((r_wstate == W_RESP) && r_werr) ? c_axi_resp_slverr
                                                          : c_axi_resp_okay;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t               r_rstate;
    rd_state_t               w_rstate_nxt;
    logic [AXI_ID_W-1:0]     r_ar_id;
    logic [MEM_ADDR_W-1:0]   r_raddr;
    logic [AXI_LEN_W-1:0]    r_ar_len;
    logic [AXI_LEN_W:0]      r_rcnt;      // beats issued to the RAM so far
    logic                    r_ar_fixed;
    logic                    r_rvalid;
    logic                    r_rlast;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_rd_issue;
    logic w_beats_left;

    assign w_ar_hs      = cke_i & axi_arvalid_i & (r_rstate == R_IDLE);
    assign w_r_hs       = cke_i & r_rvalid & axi_rready_i;
    assign w_beats_left = (r_rcnt <= {1'b0, r_ar_len});
    // Issue only when the output slot is free or is being drained this
    // cycle; otherwise the RAM output register holds the stalled beat.
    assign w_rd_issue   = cke_i & (r_rstate == R_BURST) & w_beats_left
                          & (~r_rvalid | axi_rready_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rstate <= R_IDLE;
        end else if (cke_i) begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        axi_arready_o = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                axi_arready_o = 1'b1;
                if (w_ar_hs) w_rstate_nxt = R_BURST;
            end
            R_BURST: begin
                if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ar_id    <= '0;
            r_raddr    <= '0;
            r_ar_len   <= '0;
            r_ar_fixed <= 1'b0;
            r_rcnt     <= '0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
        end else if (w_ar_hs) begin
            r_ar_id    <= axi_arid_i;
            r_raddr    <= axi_araddr_i[MEM_ADDR_W+c_off-1 -: MEM_ADDR_W];
            r_ar_len   <= axi_arlen_i;
            r_ar_fixed <= burst_holds(axi_arburst_i);
            r_rcnt     <= '0;
        end else if (w_rd_issue) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_rcnt[AXI_LEN_W-1:0] == r_ar_len);
            r_rcnt   <= r_rcnt + c_rcnt_one;
            if (!r_ar_fixed) r_raddr <= r_raddr + c_word_one;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end
    end

    assign axi_rid_o    = r_ar_id;
    assign axi_rresp_o  = c_axi_resp_okay;
    assign axi_rvalid_o = r_rvalid;
    assign axi_rlast_o  = r_rlast;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    iob_soc_versat_axi_ram_mem #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_mem (
        .clk     (clk_i),
        .rst     (arst_i),
        .i_we    (w_w_hs),
        .i_waddr (r_waddr),
        .i_wstrb (axi_wstrb_i),
        .i_wdata (axi_wdata_i),
        .i_re    (w_rd_issue),
        .i_raddr (r_raddr),
        .o_rdata (axi_rdata_o)
    );

    // Inputs that carry no meaning for this RAM (full-word stepping, no
    // locking/caching/protection/QoS, aliased upper address bits).
    logic w_unused_inputs;
    assign w_unused_inputs = ^{axi_awaddr_i, axi_awsize_i, axi_awlock_i,
                               axi_awcache_i, axi_awprot_i, axi_awqos_i,
                               axi_araddr_i, axi_arsize_i, axi_arlock_i,
                               axi_arcache_i, axi_arprot_i, axi_arqos_i};

endmodule
`default_nettype wire

// File: tb/tb_iob_soc_versat_axi_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_soc_versat_axi_ram
// Description : Self-checking bench for the AXI4 subordinate RAM. A word-
//               indexed associative array holds the expected RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iob_soc_versat_axi_ram;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        arst_i = 1'b1;
    logic        cke_i = 1'b1;
    logic [3:0]  axi_awid_i = '0;
    logic [23:0] axi_awaddr_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [2:0]  axi_awsize_i = 3'd2;
    logic [1:0]  axi_awburst_i = 2'b01;
    logic        axi_awlock_i = 1'b0;
    logic [3:0]  axi_awcache_i = '0;
    logic [2:0]  axi_awprot_i = '0;
    logic [3:0]  axi_awqos_i = '0;
    logic        axi_awvalid_i = 1'b0;
    logic        axi_awready_o;
    logic [31:0] axi_wdata_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_wlast_i = 1'b0;
    logic        axi_wvalid_i = 1'b0;
    logic        axi_wready_o;
    logic [3:0]  axi_bid_o;
    logic [1:0]  axi_bresp_o;
    logic        axi_bvalid_o;
    logic        axi_bready_i = 1'b0;
    logic [3:0]  axi_arid_i = '0;
    logic [23:0] axi_araddr_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [2:0]  axi_arsize_i = 3'd2;
    logic [1:0]  axi_arburst_i = 2'b01;
    logic        axi_arlock_i = 1'b0;
    logic [3:0]  axi_arcache_i = '0;
    logic [2:0]  axi_arprot_i = '0;
    logic [3:0]  axi_arqos_i = '0;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic        axi_rlast_o;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;

    iob_soc_versat_axi_ram dut (
        .clk_i(clk), .arst_i(arst_i), .cke_i(cke_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i), .axi_awlock_i(axi_awlock_i),
        .axi_awcache_i(axi_awcache_i), .axi_awprot_i(axi_awprot_i), .axi_awqos_i(axi_awqos_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i), .axi_arlock_i(axi_arlock_i),
        .axi_arcache_i(axi_arcache_i), .axi_arprot_i(axi_arprot_i), .axi_arqos_i(axi_arqos_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [int];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rbuf [256];

    typedef struct {
        logic [23:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [23:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name, input int n);
        if (n >= TMO) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles, expected handshake", name, n);
        end
    endtask

    // Word index: byte offset dropped, upper bits alias, FIXED holds
    function automatic int widx(input logic [23:0] a, input int beat, input logic [1:0] burst);
        int w;
        w = int'(a[17:2]);
        if (burst != 2'b00) w = w + beat;
        return w % 65536;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic axi_write(input logic [23:0] addr, input int len, input logic [1:0] burst,
                             input logic [3:0] id, input int wlast_at,
                             output logic [1:0] resp, output logic [3:0] bid_got);
        int n;
        int w;
        logic [31:0] old;
        axi_awaddr_i = addr; axi_awlen_i = 8'(len); axi_awburst_i = burst;
        axi_awid_i = id; axi_awvalid_i = 1'b1;
        n = 0;
        while (!axi_awready_o && n < TMO) begin @(posedge clk); #1; n++; end
        tmo("aw handshake", n);
        @(posedge clk); #1;
        axi_awvalid_i = 1'b0;
        for (int b = 0; b <= len; b++) begin
            axi_wdata_i = wbuf[b]; axi_wstrb_i = sbuf[b];
            axi_wlast_i = (b == wlast_at); axi_wvalid_i = 1'b1;
            n = 0;
            while (!axi_wready_o && n < TMO) begin @(posedge clk); #1; n++; end
            tmo("w handshake", n);
            @(posedge clk); #1;
            w   = widx(addr, b, burst);
            old = model.exists(w) ? model[w] : 32'h0;
            model[w] = merge(old, wbuf[b], sbuf[b]);
        end
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0; axi_bready_i = 1'b1;
        n = 0;
        while (!axi_bvalid_o && n < TMO) begin @(posedge clk); #1; n++; end
        tmo("b handshake", n);
        resp = axi_bresp_o; bid_got = axi_bid_o;
        @(posedge clk); #1;
        axi_bready_i = 1'b0;
    endtask

    // mode 0: rready=1, 1: toggles 1/0, 2: random
    task automatic axi_read(input logic [23:0] addr, input int len, input logic [1:0] burst,
                            input logic [3:0] id, input int mode, input bit chk_lat,
                            input string tag);
        int n, beats, lat;
        bit stalled, seen;
        logic [31:0] held;
        axi_araddr_i = addr; axi_arlen_i = 8'(len); axi_arburst_i = burst;
        axi_arid_i = id; axi_arvalid_i = 1'b1;
        n = 0;
        while (!axi_arready_o && n < TMO) begin @(posedge clk); #1; n++; end
        tmo({tag, " ar handshake"}, n);
        @(posedge clk); #1;
        axi_arvalid_i = 1'b0;
        beats = 0; n = 0; lat = 1; stalled = 0; seen = 0; held = '0;
        while (beats <= len && n < TMO * 4) begin
            case (mode)
                0:       axi_rready_i = 1'b1;
                1:       axi_rready_i = (n % 2 == 0);
                default: axi_rready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (axi_rvalid_o) begin
                if (!seen && chk_lat) chk({tag, " first rvalid cycle"}, 64'(lat), 64'd2);
                seen = 1;
                if (stalled) chk({tag, " rdata stable"}, 64'(axi_rdata_o), 64'(held));
                if (axi_rready_i) begin
                    rbuf[beats] = axi_rdata_o;
                    chk($sformatf("%s rlast beat %0d", tag, beats), 64'(axi_rlast_o),
                        64'(beats == len));
                    chk({tag, " rid"}, 64'(axi_rid_o), 64'(id));
                    beats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = axi_rdata_o;
                end
            end
            @(posedge clk); #1;
            n++; lat++;
        end
        axi_rready_i = 1'b0;
        if (beats <= len) begin
            total++; bad++;
            $display("FAIL %s: got %0d beats, expected %0d", tag, beats, len + 1);
        end
    endtask

    task automatic chk_model(input logic [23:0] addr, input int len, input logic [1:0] burst,
                             input string tag);
        int w;
        for (int b = 0; b <= len; b++) begin
            w = widx(addr, b, burst);
            chk($sformatf("%s data beat %0d", tag, b), 64'(rbuf[b]), 64'(model[w]));
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  bidg;
        logic [23:0] a;
        int          len, start;
        logic [1:0]  burst;
        logic [3:0]  id;

        tbl[0] = '{24'h000010, 32'hDEADBEEF, 4'hF, 24'h000010, 32'hDEADBEEF};
        tbl[1] = '{24'h000020, 32'hFFFFFFFF, 4'hF, 24'h000020, 32'hFFFFFFFF};
        tbl[2] = '{24'h000020, 32'h00000000, 4'h5, 24'h000020, 32'hFF00FF00};
        tbl[3] = '{24'h000020, 32'h12345678, 4'h8, 24'h000020, 32'h1200FF00};
        tbl[4] = '{24'h000020, 32'hAABBCCDD, 4'h2, 24'h000020, 32'h1200CC00};
        tbl[5] = '{24'h040020, 32'h00000077, 4'h1, 24'h000020, 32'h1200CC77};
        tbl[6] = '{24'h000030, 32'hCAFEF00D, 4'hF, 24'h000013, 32'hDEADBEEF};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst awready", 64'(axi_awready_o), 64'd1);
        chk("rst arready", 64'(axi_arready_o), 64'd1);
        chk("rst wready",  64'(axi_wready_o),  64'd0);
        chk("rst bvalid",  64'(axi_bvalid_o),  64'd0);
        chk("rst rvalid",  64'(axi_rvalid_o),  64'd0);
        chk("rst rlast",   64'(axi_rlast_o),   64'd0);
        chk("rst ids/resp/rdata",
            64'({axi_bid_o, axi_rid_o, axi_bresp_o, axi_rresp_o, axi_rdata_o}), 64'd0);
        arst_i = 1'b0;
        @(posedge clk); #1;

        // ---------------- table: single-beat writes and readback ----------------
        for (int i = 0; i < 7; i++) begin
            wbuf[0] = tbl[i].wdata; sbuf[0] = tbl[i].wstrb;
            axi_write(tbl[i].waddr, 0, 2'b01, 4'(i), 0, resp, bidg);
            chk($sformatf("tbl%0d bresp", i), 64'(resp), 64'd0);
            chk($sformatf("tbl%0d bid", i), 64'(bidg), 64'(i));
            axi_read(tbl[i].raddr, 0, 2'b01, 4'(15 - i), 0, 1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d rdata", i), 64'(rbuf[0]), 64'(tbl[i].exp));
        end
        chk("arready after last beat", 64'(axi_arready_o), 64'd1);

        // ---------------- INCR len=15, readback with rready toggling ----------------
        for (int b = 0; b < 16; b++) begin wbuf[b] = 32'(b); sbuf[b] = 4'hF; end
        axi_write(24'h000100, 15, 2'b01, 4'h3, 15, resp, bidg);
        chk("incr16 bresp", 64'(resp), 64'd0);
        axi_read(24'h000100, 15, 2'b01, 4'h6, 1, 1, "incr16");
        for (int b = 0; b < 16; b++) chk($sformatf("incr16 beat %0d", b), 64'(rbuf[b]), 64'(b));

        // ---------------- FIXED len=3 ----------------
        wbuf[0] = 32'h5555AAAA; sbuf[0] = 4'hF;
        axi_write(24'h000044, 0, 2'b01, 4'h1, 0, resp, bidg);
        for (int b = 0; b < 4; b++) begin wbuf[b] = 32'(b + 1); sbuf[b] = 4'hF; end
        axi_write(24'h000040, 3, 2'b00, 4'h2, 3, resp, bidg);
        chk("fixed bresp", 64'(resp), 64'd0);
        axi_read(24'h000040, 0, 2'b01, 4'h2, 0, 1, "fixed40");
        chk("fixed 0x40", 64'(rbuf[0]), 64'd4);
        axi_read(24'h000044, 0, 2'b01, 4'h2, 0, 1, "fixed44");
        chk("fixed 0x44 untouched", 64'(rbuf[0]), 64'h5555AAAA);

        // ---------------- wlast protocol errors ----------------
        for (int b = 0; b < 4; b++) begin wbuf[b] = 32'hA0 + 32'(b); sbuf[b] = 4'hF; end
        axi_write(24'h000400, 3, 2'b01, 4'hA, 1, resp, bidg);
        chk("early wlast bresp", 64'(resp), 64'h2);
        chk("early wlast bid", 64'(bidg), 64'hA);
        axi_read(24'h000400, 3, 2'b01, 4'h0, 0, 0, "early wlast rd");
        for (int b = 0; b < 4; b++)
            chk($sformatf("early wlast beat %0d", b), 64'(rbuf[b]), 64'hA0 + 64'(b));
        axi_write(24'h000410, 1, 2'b01, 4'h5, 99, resp, bidg);
        chk("missing wlast bresp", 64'(resp), 64'h2);
        axi_write(24'h000410, 1, 2'b01, 4'h5, 1, resp, bidg);
        chk("err cleared bresp", 64'(resp), 64'h0);

        // ---------------- reset mid read burst ----------------
        axi_araddr_i = 24'h000100; axi_arlen_i = 8'd7; axi_arburst_i = 2'b01;
        axi_arid_i = 4'h9; axi_arvalid_i = 1'b1; axi_rready_i = 1'b0;
        @(posedge clk); #1;
        axi_arvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset rvalid", 64'(axi_rvalid_o), 64'd1);
        arst_i = 1'b1;
        @(posedge clk); #1;
        chk("mid-reset rvalid", 64'(axi_rvalid_o), 64'd0);
        chk("mid-reset arready", 64'(axi_arready_o), 64'd1);
        arst_i = 1'b0;
        @(posedge clk); #1;
        axi_read(24'h000104, 0, 2'b01, 4'h4, 0, 1, "post-reset");
        chk("post-reset rdata", 64'(rbuf[0]), 64'd1);

        // ---------------- same-word read/write collision ----------------
        wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
        axi_write(24'h000200, 0, 2'b01, 4'h0, 0, resp, bidg);
        axi_awaddr_i = 24'h000200; axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
        axi_awid_i = 4'h7; axi_awvalid_i = 1'b1;
        @(posedge clk); #1;
        axi_awvalid_i = 1'b0;
        axi_araddr_i = 24'h000200; axi_arlen_i = 8'd0; axi_arid_i = 4'h8;
        axi_arvalid_i = 1'b1; axi_rready_i = 1'b1;
        @(posedge clk); #1;
        axi_arvalid_i = 1'b0;
        axi_wdata_i = 32'h600DCAFE; axi_wstrb_i = 4'hF; axi_wlast_i = 1'b1; axi_wvalid_i = 1'b1;
        @(posedge clk); #1;
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
        chk("collision rvalid", 64'(axi_rvalid_o), 64'd1);
        chk("collision old data", 64'(axi_rdata_o), 64'h0BADF00D);
        @(posedge clk); #1;
        axi_rready_i = 1'b0;
        chk("collision bvalid", 64'(axi_bvalid_o), 64'd1);
        chk("collision bid", 64'(axi_bid_o), 64'h7);
        axi_bready_i = 1'b1;
        @(posedge clk); #1;
        axi_bready_i = 1'b0;
        model[widx(24'h000200, 0, 2'b01)] = 32'h600DCAFE;
        axi_read(24'h000200, 0, 2'b01, 4'h8, 0, 1, "collision after");
        chk("collision new data", 64'(rbuf[0]), 64'h600DCAFE);

        // ---------------- clock enable freeze ----------------
        cke_i = 1'b0;
        axi_awvalid_i = 1'b1; axi_awaddr_i = 24'h000300;
        repeat (3) @(posedge clk);
        #1;
        chk("cke0 wready", 64'(axi_wready_o), 64'd0);
        axi_awvalid_i = 1'b0;
        cke_i = 1'b1;
        @(posedge clk); #1;
        chk("cke1 awready", 64'(axi_awready_o), 64'd1);

        // ---------------- randomized traffic vs model ----------------
        for (int b = 0; b < 64; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'hF; end
        axi_write(24'h001000, 63, 2'b01, 4'h1, 63, resp, bidg);
        for (int t = 0; t < 40; t++) begin
            burst = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            len   = $urandom_range(0, 7);
            start = $urandom_range(0, 63 - len);
            a     = 24'(32'h1000 + 32'(start) * 4 + $urandom_range(0, 3)
                        + ($urandom_range(0, 1) << 18));
            id    = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= len; b++) begin wbuf[b] = $urandom; sbuf[b] = 4'($urandom); end
                axi_write(a, len, burst, id, len, resp, bidg);
                chk($sformatf("rand%0d bresp", t), 64'(resp), 64'd0);
                chk($sformatf("rand%0d bid", t), 64'(bidg), 64'(id));
            end else begin
                axi_read(a, len, burst, id, $urandom_range(0, 2), 0, $sformatf("rand%0d", t));
                chk_model(a, len, burst, $sformatf("rand%0d", t));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
